// File: rtl/vector_gates_skid_if.sv
// rtl/vector_gates_skid_if.sv - valid/ready word bus between gate block, skid stage and sink
interface vector_gates_skid_if #(
  parameter int W = 3
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_or_bitwise;
  logic           in_or_logical;
  logic [2*W-1:0] in_not;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_or_bitwise;
  logic           out_or_logical;
  logic [2*W-1:0] out_not;

  modport slave (
    input  in_valid, in_or_bitwise, in_or_logical, in_not, out_ready,
    output in_ready, out_valid, out_or_bitwise, out_or_logical, out_not
  );

  modport master (
    output in_valid, in_or_bitwise, in_or_logical, in_not, out_ready,
    input  in_ready, out_valid, out_or_bitwise, out_or_logical, out_not
  );
endinterface

// File: rtl/vector_gates_skid.sv
// rtl/vector_gates_skid.sv - two-entry skid output stage for gate-result words with true counter and sticky error
module vector_gates_skid #(
  parameter int W     = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  vector_gates_skid_if.slave bus,
  output logic [CNT_W-1:0] true_count,
  output logic             err
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam int DW = 3*W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t        state;
  logic          main_valid;
  logic          skid_valid;
  logic [DW-1:0] main_word;
  logic [DW-1:0] skid_word;
  logic [DW-1:0] in_word;
  logic          accept;
  logic          pop;

  assign in_word = {bus.in_or_bitwise, bus.in_or_logical, bus.in_not};
  assign {bus.out_or_bitwise, bus.out_or_logical, bus.out_not} = main_word;
  assign bus.out_valid = main_valid;
  // in_ready depends only on the skid register, so upstream never sees a path from out_ready
  assign bus.in_ready  = ~skid_valid & ~reset;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = main_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_word  <= '0;
      skid_word  <= '0;
      true_count <= '0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_word  <= in_word;
            main_valid <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_word <= in_word;
          end else if (accept) begin
            skid_word  <= in_word;
            skid_valid <= 1'b1;
            state      <= TWO;
          end else if (pop) begin
            main_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_word  <= skid_word;
            skid_valid <= 1'b0;
            state      <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase

      if (accept && bus.in_or_logical && (true_count != CNT_MAX))
        true_count <= true_count + 1'b1;
      // inconsistent words still flow through; only the flag records them
      if (accept && (bus.in_or_logical != (|bus.in_or_bitwise)))
        err <= 1'b1;
    end
  end
endmodule
